kernel_input_join: RTL

// - Upstream feeder for the kernel top: joins two independent input streams (vin0, vin1),

---
 rtl/kernel_input_join_pkg.sv | 24 ++
 rtl/kernel_input_join_if.sv | 33 +++
 rtl/kernel_input_fifo.sv | 67 ++++++
 rtl/kernel_input_join.sv | 120 ++++++++++++
 4 files changed

// File: rtl/kernel_input_join_pkg.sv
// Shared definitions for the kernel input join block.
// - state_e : run-control FSM encoding (IDLE=0, RUN=1, DONE=2)
// - clog2   : ceiling log2, used to size the FIFO pointers
package kernel_input_join_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/kernel_input_join_if.sv
// Stream bundle between the two memory readers, the join block and the kernel top.
// - s0_data/s0_valid/s0_ready : lane-0 input stream
// - s1_data/s1_valid/s1_ready : lane-1 input stream
// - kt_vin0_s0/kt_vin1_s0     : joined output pair
// - ivalid/iready             : joined-pair handshake
// Modports: master = the side feeding the streams and consuming the pair,
//           slave  = the join block.
interface kernel_input_join_if #(
  parameter int unsigned STREAMW = 32
);

  logic [STREAMW-1:0] s0_data;
  logic               s0_valid;
  logic               s0_ready;
  logic [STREAMW-1:0] s1_data;
  logic               s1_valid;
  logic               s1_ready;
  logic [STREAMW-1:0] kt_vin0_s0;
  logic [STREAMW-1:0] kt_vin1_s0;
  logic               ivalid;
  logic               iready;

  modport master (
    output s0_data, s0_valid, s1_data, s1_valid, iready,
    input  s0_ready, s1_ready, kt_vin0_s0, kt_vin1_s0, ivalid
  );

  modport slave (
    input  s0_data, s0_valid, s1_data, s1_valid, iready,
    output s0_ready, s1_ready, kt_vin0_s0, kt_vin1_s0, ivalid
  );

endinterface

// File: rtl/kernel_input_fifo.sv
// Registered-head synchronous FIFO, one per input lane.
// - clk, rst  : clock, asynchronous active-low reset
// - push/data : write data when push is high (ignored when full)
// - pop       : advance the head when high (ignored when empty)
// - head      : current oldest entry, straight from the storage registers
// - full/empty: occupancy flags from the registered count only
// A word written in cycle t is visible at head in t+1; there is no bypass path.
module kernel_input_fifo
  import kernel_input_join_pkg::*;
#(
  parameter int unsigned STREAMW    = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [STREAMW-1:0] push_data,
  input  logic               pop,
  output logic [STREAMW-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int unsigned PtrW = clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [STREAMW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q;
  logic [PtrW-1:0]    rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               do_push;
  logic               do_pop;

  always_comb begin
    full    = (count_q == CntW'(FIFO_DEPTH));
    empty   = (count_q == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    head    = mem_q[rd_ptr_q];
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/kernel_input_join.sv
// Joins two independently handshaked input streams into one lock-step pair for the
// kernel top, buffering each lane so the two readers may run skewed.
// - clk, rst  : clock, asynchronous active-low reset
// - start     : pulse; begins a run when idle
// - n_items   : elements per lane for the run, sampled when start is accepted
// - busy      : high while running
// - done      : one-cycle pulse after the last pair is handed over
// - bus       : stream bundle (slave side): two input lanes and the joined pair
module kernel_input_join
  import kernel_input_join_pkg::*;
#(
  parameter int unsigned STREAMW    = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNTW       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CNTW-1:0] n_items,
  output logic            busy,
  output logic            done,
  kernel_input_join_if.slave bus
);

  state_e          state_q;
  logic [CNTW-1:0] n_reg_q;
  logic [CNTW-1:0] acc0_q;
  logic [CNTW-1:0] acc1_q;
  logic [CNTW-1:0] emit_cnt_q;

  logic               run;
  logic               full0, empty0, full1, empty1;
  logic               push0, push1, pop;
  logic               last_pop;
  logic [STREAMW-1:0] head0, head1;

  kernel_input_fifo #(
    .STREAMW    (STREAMW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (bus.s0_data),
    .pop       (pop),
    .head      (head0),
    .full      (full0),
    .empty     (empty0)
  );

  kernel_input_fifo #(
    .STREAMW    (STREAMW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (bus.s1_data),
    .pop       (pop),
    .head      (head1),
    .full      (full1),
    .empty     (empty1)
  );

  // Ready depends only on current occupancy, so a same-cycle pop never opens a full lane.
  // The acc compare caps each lane at n_reg words, so surplus source words stay upstream.
  always_comb begin
    run            = (state_q == StRun);
    bus.s0_ready   = run & ~full0 & (acc0_q < n_reg_q);
    bus.s1_ready   = run & ~full1 & (acc1_q < n_reg_q);
    push0          = bus.s0_valid & bus.s0_ready;
    push1          = bus.s1_valid & bus.s1_ready;
    bus.ivalid     = run & ~empty0 & ~empty1;
    bus.kt_vin0_s0 = head0;
    bus.kt_vin1_s0 = head1;
    pop            = bus.ivalid & bus.iready;
    last_pop       = pop & (emit_cnt_q == n_reg_q - 1'b1);
    busy           = run;
    done           = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      n_reg_q    <= '0;
      acc0_q     <= '0;
      acc1_q     <= '0;
      emit_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc0_q     <= '0;
            acc1_q     <= '0;
            emit_cnt_q <= '0;
            if (n_items != '0) begin
              n_reg_q <= n_items;
              state_q <= StRun;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StRun: begin
          if (push0) acc0_q <= acc0_q + 1'b1;
          if (push1) acc1_q <= acc1_q + 1'b1;
          if (pop) emit_cnt_q <= emit_cnt_q + 1'b1;
          if (last_pop) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
